// File: rtl/axi4lite_apb_bridge_mux.sv
// AXI4-Lite slave to multi-slave APB master bridge with read/write arbitration,
// out-of-window decode errors and a PREADY timeout so a hung peripheral cannot stall AXI.
module axi4lite_apb_bridge_mux #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_SLAVES    = 4,
  parameter int                    SLV_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h4000_0000,
  parameter int                    TIMEOUT       = 16
) (
  input  logic                             i_aclk,
  input  logic                             i_areset,
  input  logic [ADDR_WIDTH-1:0]            i_awaddr,
  input  logic                             i_awvalid,
  output logic                             o_awready,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [DATA_WIDTH/8-1:0]          i_wstrb,
  input  logic                             i_wvalid,
  output logic                             o_wready,
  output logic [1:0]                       o_bresp,
  output logic                             o_bvalid,
  input  logic                             i_bready,
  input  logic [ADDR_WIDTH-1:0]            i_araddr,
  input  logic                             i_arvalid,
  output logic                             o_arready,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic [1:0]                       o_rresp,
  output logic                             o_rvalid,
  input  logic                             i_rready,
  output logic [ADDR_WIDTH-1:0]            o_paddr,
  output logic [NUM_SLAVES-1:0]            o_psel,
  output logic                             o_penable,
  output logic                             o_pwrite,
  output logic [DATA_WIDTH-1:0]            o_pwdata,
  output logic [DATA_WIDTH/8-1:0]          o_pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata,
  input  logic [NUM_SLAVES-1:0]            i_pready,
  input  logic [NUM_SLAVES-1:0]            i_pslverr,
  output logic                             o_error
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] WIN_SIZE = (ADDR_WIDTH+1)'(NUM_SLAVES) << SLV_ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                  r_state;
  logic                    r_last_wr;
  logic                    r_wr;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic                    r_error;

  logic                    w_wr_pend;
  logic                    w_rd_pend;
  logic                    w_gnt_wr;
  logic                    w_gnt_rd;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_in_range;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_prdata;
  logic                    w_pready;
  logic                    w_pslverr;
  logic                    w_fail;
  logic                    w_done;

  // On a read/write conflict the direction not served last wins.
  assign w_wr_pend = i_awvalid & i_wvalid;
  assign w_rd_pend = i_arvalid;
  assign w_gnt_wr  = (r_state == S_IDLE) & ~i_areset & w_wr_pend & (~w_rd_pend | ~r_last_wr);
  assign w_gnt_rd  = (r_state == S_IDLE) & ~i_areset & w_rd_pend & (~w_wr_pend | r_last_wr);

  assign w_addr     = w_gnt_wr ? i_awaddr : i_araddr;
  assign w_offset   = w_addr - BASE_ADDR;
  assign w_in_range = {1'b0, w_offset} < WIN_SIZE;
  assign w_idx      = w_offset[SLV_ADDR_BITS +: IDX_W];

  always_comb begin
    w_prdata  = '0;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_prdata  = i_prdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_pready  = i_pready[i];
        w_pslverr = i_pslverr[i];
      end
    end
  end

  assign w_fail = ~w_pready | w_pslverr;
  assign w_done = r_wr ? i_bready : i_rready;

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state   <= S_IDLE;
      r_last_wr <= 1'b0;
      r_wr      <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_paddr   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_error   <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_wr || w_gnt_rd) begin
            r_wr      <= w_gnt_wr;
            r_last_wr <= w_gnt_wr;
            if (w_in_range) begin
              r_state  <= S_SETUP;
              r_idx    <= w_idx;
              r_psel   <= NUM_SLAVES'(1) << w_idx;
              r_paddr  <= w_addr;
              r_pwrite <= w_gnt_wr;
              if (w_gnt_wr) begin
                r_pwdata <= i_wdata;
                r_pstrb  <= i_wstrb;
              end else begin
                r_pstrb  <= '0;
              end
            end else begin
              // Decode error: answer straight away without touching APB.
              r_state <= S_RESP;
              r_error <= 1'b1;
              if (w_gnt_wr) begin
                r_bvalid <= 1'b1;
                r_bresp  <= 2'b11;
              end else begin
                r_rvalid <= 1'b1;
                r_rresp  <= 2'b11;
                r_rdata  <= '0;
              end
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY wins over the timeout when both land on the same cycle.
          if (w_pready || r_cnt == CNT_W'(TIMEOUT)) begin
            r_state   <= S_RESP;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_error   <= w_fail;
            if (r_wr) begin
              r_bvalid <= 1'b1;
              r_bresp  <= w_fail ? 2'b10 : 2'b00;
            end else begin
              r_rvalid <= 1'b1;
              r_rresp  <= w_fail ? 2'b10 : 2'b00;
              r_rdata  <= w_pready ? w_prdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (w_done) begin
            r_state  <= S_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_awready = w_gnt_wr;
  assign o_wready  = w_gnt_wr;
  assign o_arready = w_gnt_rd;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_rvalid  = r_rvalid;
  assign o_rresp   = r_rresp;
  assign o_rdata   = r_rdata;
  assign o_paddr   = r_paddr;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;
  assign o_pwdata  = r_pwdata;
  assign o_pstrb   = r_pstrb;
  assign o_error   = r_error;

endmodule

// File: tb/tb_axi4lite_apb_bridge_mux.sv
// Self-checking bench for axi4lite_apb_bridge_mux: directed vector table, hand-written
// arbitration/reset sequences and randomized transfers against a transaction-level model.
module tb_axi4lite_apb_bridge_mux;
  localparam int          NSLV    = 4;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam int          WIN     = 4096;
  localparam int          TO      = 16;

  logic        clk;
  logic        rst;
  logic [31:0] awAddr;
  logic        awValid;
  logic        awReady;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        wValid;
  logic        wReady;
  logic [1:0]  bResp;
  logic        bValid;
  logic        bReady;
  logic [31:0] arAddr;
  logic        arValid;
  logic        arReady;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rValid;
  logic        rReady;
  logic [31:0] pAddr;
  logic [3:0]  pSel;
  logic        pEnable;
  logic        pWrite;
  logic [31:0] pWdata;
  logic [3:0]  pStrb;
  logic [127:0] pRdata;
  logic [3:0]  pReady;
  logic [3:0]  pSlvErr;
  logic        errPulse;

  int checks = 0;
  int errors = 0;

  int          cfgWaits;
  bit          cfgErr;
  int          waitCnt;
  logic [31:0] slvData [NSLV];

  axi4lite_apb_bridge_mux dut (
    .i_aclk(clk), .i_areset(rst),
    .i_awaddr(awAddr), .i_awvalid(awValid), .o_awready(awReady),
    .i_wdata(wData), .i_wstrb(wStrb), .i_wvalid(wValid), .o_wready(wReady),
    .o_bresp(bResp), .o_bvalid(bValid), .i_bready(bReady),
    .i_araddr(arAddr), .i_arvalid(arValid), .o_arready(arReady),
    .o_rdata(rData), .o_rresp(rResp), .o_rvalid(rValid), .i_rready(rReady),
    .o_paddr(pAddr), .o_psel(pSel), .o_penable(pEnable), .o_pwrite(pWrite),
    .o_pwdata(pWdata), .o_pstrb(pStrb),
    .i_prdata(pRdata), .i_pready(pReady), .i_pslverr(pSlvErr),
    .o_error(errPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // APB peripheral model: the selected slave raises PREADY after cfgWaits ACCESS cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) waitCnt <= 0;
    else if (pSel != 4'b0 && pEnable) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  always_comb begin
    pReady  = '0;
    pSlvErr = '0;
    pRdata  = '0;
    for (int i = 0; i < NSLV; i++) begin
      pReady[i]  = pSel[i] & pEnable & (waitCnt >= cfgWaits);
      pSlvErr[i] = pSel[i] & pEnable & (waitCnt >= cfgWaits) & cfgErr;
      pRdata[i*32 +: 32] = slvData[i];
    end
  end

  typedef struct {
    bit          isWr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          waits;
    bit          slverr;
    int          rdyDly;
    int          expLat;
    logic [1:0]  expResp;
    logic [3:0]  expPsel;
    logic [31:0] expRdata;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation from address window, wait count and error flag.
  task automatic refModel(input bit isWr, input logic [31:0] addr, input int waits, input bit slverr,
                          output int lat, output logic [1:0] resp, output logic [3:0] psel,
                          output logic [31:0] rdat);
    logic [31:0] off;
    int          idx;
    off = addr - BASE;
    if (off >= 32'(NSLV * WIN)) begin
      lat = 1; resp = 2'b11; psel = 4'b0; rdat = 32'h0;
    end else begin
      idx  = int'(off / WIN);
      psel = 4'b1 << idx;
      if (waits > TO) begin
        lat = 3 + TO; resp = 2'b10; rdat = 32'h0;
      end else begin
        lat  = 3 + waits;
        resp = slverr ? 2'b10 : 2'b00;
        rdat = isWr ? 32'h0 : slvData[idx];
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int   n;
    bit   seen;
    logic vld;
    logic [1:0] rsp;
    cfgWaits = v.waits;
    cfgErr   = v.slverr;
    bReady   = (v.rdyDly == 0);
    rReady   = (v.rdyDly == 0);
    @(negedge clk);
    if (v.isWr) begin
      awAddr = v.addr; wData = v.data; wStrb = v.strb; awValid = 1'b1; wValid = 1'b1;
    end else begin
      arAddr = v.addr; arValid = 1'b1;
    end
    #1;
    checkOutput("addrReady", v.isWr ? (awReady & wReady) : arReady, 1);
    @(negedge clk);
    awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
    n = 1;
    checkOutput("setupPsel", pSel, v.expPsel);
    if (v.expPsel != 4'b0) begin
      checkOutput("setupPenable", pEnable, 0);
      checkOutput("setupPaddr", pAddr, v.addr);
      checkOutput("setupPwrite", pWrite, v.isWr);
      checkOutput("setupPstrb", pStrb, v.isWr ? v.strb : 4'h0);
      if (v.isWr) checkOutput("setupPwdata", pWdata, v.data);
    end
    seen = 1'b0;
    forever begin
      if (n == 2) checkOutput("accessPenable", pEnable, 1);
      vld = v.isWr ? bValid : rValid;
      if (vld) begin seen = 1'b1; break; end
      if (n >= v.expLat + 8) break;
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, v.expLat);
    if (!seen) begin
      bReady = 1'b1; rReady = 1'b1;
      repeat (TO + 8) @(negedge clk);
      return;
    end
    rsp = v.isWr ? bResp : rResp;
    checkOutput("resp", rsp, v.expResp);
    checkOutput("otherValid", v.isWr ? rValid : bValid, 0);
    checkOutput("otherResp", v.isWr ? rResp : bResp, 2'b00);
    if (!v.isWr) checkOutput("rdata", rData, v.expRdata);
    checkOutput("respPsel", pSel, 4'b0);
    checkOutput("respPenable", pEnable, 0);
    checkOutput("errorPulse", errPulse, v.expResp != 2'b00);
    for (int d = 0; d < v.rdyDly; d++) begin
      @(negedge clk);
      checkOutput("holdValid", v.isWr ? bValid : rValid, 1);
      checkOutput("holdResp", v.isWr ? bResp : rResp, v.expResp);
      if (!v.isWr) checkOutput("holdRdata", rData, v.expRdata);
      if (d == 0) checkOutput("errorOneCycle", errPulse, 0);
    end
    bReady = 1'b1;
    rReady = 1'b1;
    @(negedge clk);
    checkOutput("validDrop", v.isWr ? bValid : rValid, 0);
    if (v.rdyDly == 0) checkOutput("errorOneCycle", errPulse, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [10];
    int   grantDir [$];
    int   grantCyc [$];
    vec_t rv;

    slvData = '{32'h1111_0000, 32'h2222_1111, 32'h3333_2222, 32'h1234_5678};
    cfgWaits = 0; cfgErr = 1'b0;
    rst = 1'b1;
    awAddr = '0; awValid = 1'b0; wData = '0; wStrb = '0; wValid = 1'b0; bReady = 1'b1;
    arAddr = '0; arValid = 1'b0; rReady = 1'b1;

    vecs[0] = '{1, 32'h4000_1004, 32'hDEAD_BEEF, 4'hF, 0,    0, 0, 3,  2'b00, 4'b0010, 32'h0};
    vecs[1] = '{0, 32'h4000_3010, 32'h0,         4'h0, 3,    0, 2, 6,  2'b00, 4'b1000, 32'h1234_5678};
    vecs[2] = '{0, 32'h5000_0000, 32'h0,         4'h0, 0,    0, 0, 1,  2'b11, 4'b0000, 32'h0};
    vecs[3] = '{1, 32'h4000_2000, 32'hCAFE_F00D, 4'hF, 1000, 0, 0, 19, 2'b10, 4'b0100, 32'h0};
    vecs[4] = '{1, 32'h4000_0008, 32'h0000_55AA, 4'h3, 0,    1, 1, 3,  2'b10, 4'b0001, 32'h0};
    vecs[5] = '{0, 32'h4000_0FFC, 32'h0,         4'h0, 2,    1, 0, 5,  2'b10, 4'b0001, 32'h1111_0000};
    vecs[6] = '{0, 32'h4000_4000, 32'h0,         4'h0, 0,    0, 0, 1,  2'b11, 4'b0000, 32'h0};
    vecs[7] = '{1, 32'h3FFF_FFFC, 32'h0000_0001, 4'hF, 0,    0, 2, 1,  2'b11, 4'b0000, 32'h0};
    vecs[8] = '{0, 32'h4000_2ABC, 32'h0,         4'h0, 16,   0, 0, 19, 2'b00, 4'b0100, 32'h3333_2222};
    vecs[9] = '{0, 32'h4000_1000, 32'h0,         4'h0, 17,   0, 0, 19, 2'b10, 4'b0010, 32'h0};

    repeat (2) @(negedge clk);
    checkOutput("rstAwready", awReady, 0);
    checkOutput("rstArready", arReady, 0);
    checkOutput("rstBvalid", bValid, 0);
    checkOutput("rstRvalid", rValid, 0);
    checkOutput("rstResps", {bResp, rResp}, 4'h0);
    checkOutput("rstRdata", rData, 0);
    checkOutput("rstPsel", pSel, 0);
    checkOutput("rstPenable", pEnable, 0);
    checkOutput("rstPwrite", pWrite, 0);
    checkOutput("rstPaddr", pAddr, 0);
    checkOutput("rstPwdata", pWdata, 0);
    checkOutput("rstPstrb", pStrb, 0);
    checkOutput("rstError", errPulse, 0);
    rst = 1'b0;

    // Both directions pending continuously from reset: write first, then strict alternation.
    @(negedge clk);
    awAddr = 32'h4000_0000; wData = 32'h0BAD_F00D; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1;
    arAddr = 32'h4000_1000; arValid = 1'b1;
    for (int c = 0; c < 30 && grantDir.size() < 5; c++) begin
      #1;
      if (awReady && arReady) checkOutput("arbBothGranted", {awReady, arReady}, 2'b10);
      if (awReady) begin grantDir.push_back(1); grantCyc.push_back(c); end
      else if (arReady) begin grantDir.push_back(0); grantCyc.push_back(c); end
      @(negedge clk);
    end
    awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
    checkOutput("arbGrantCount", grantDir.size() >= 4, 1);
    for (int g = 0; g < 4 && g < grantDir.size(); g++) begin
      checkOutput($sformatf("arbGrantDir%0d", g), grantDir[g], (g % 2 == 0) ? 1 : 0);
      if (g > 0) checkOutput($sformatf("arbGrantGap%0d", g), grantCyc[g] - grantCyc[g-1], 4);
    end
    repeat (6) @(negedge clk);

    // Reset during ACCESS with BREADY low drops the transfer immediately.
    cfgWaits = 1000; bReady = 1'b0;
    @(negedge clk);
    awAddr = 32'h4000_2010; wData = 32'h5555_AAAA; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1;
    @(negedge clk);
    awValid = 1'b0; wValid = 1'b0;
    @(negedge clk);
    checkOutput("midRstInAccess", {pSel, pEnable}, 5'b0100_1);
    rst = 1'b1;
    #1;
    checkOutput("midRstPsel", pSel, 0);
    checkOutput("midRstPenable", pEnable, 0);
    checkOutput("midRstBvalid", bValid, 0);
    checkOutput("midRstPaddr", pAddr, 0);
    checkOutput("midRstPwdata", pWdata, 0);
    checkOutput("midRstPstrbPwrite", {pStrb, pWrite}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    bReady = 1'b1;
    rv = '{0, 32'h4000_1020, 32'h0, 4'h0, 1, 0, 0, 4, 2'b00, 4'b0010, 32'h2222_1111};
    applyStimulus(rv);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      int         lat;
      logic [1:0] resp;
      logic [3:0] psel;
      logic [31:0] rdat;
      for (int s = 0; s < NSLV; s++) slvData[s] = $urandom;
      rv.isWr   = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 8)
        rv.addr = BASE + 32'($urandom_range(0, NSLV-1) * WIN) + 32'($urandom_range(0, 1023) * 4);
      else if ($urandom_range(0, 1) == 1)
        rv.addr = 32'h4000_4000 + 32'($urandom_range(0, 32'hFFFF) * 4);
      else
        rv.addr = 32'h3FFF_0000 + 32'($urandom_range(0, 32'h3FFF) * 4);
      rv.data   = $urandom;
      rv.strb   = 4'($urandom_range(0, 15));
      rv.waits  = $urandom_range(0, 20);
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.rdyDly = $urandom_range(0, 2);
      refModel(rv.isWr, rv.addr, rv.waits, rv.slverr, lat, resp, psel, rdat);
      rv.expLat = lat; rv.expResp = resp; rv.expPsel = psel; rv.expRdata = rdat;
      applyStimulus(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
